bitwise_alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the 16-bit AND/OR/XOR operation unit.

---
 rtl/bitwise_pkg.sv | 17 +
 rtl/bitwise_alu_pipe_if.sv | 36 +++
 rtl/bitwise_flags.sv | 25 ++
 rtl/bitwise_alu_pipe.sv | 105 ++++++++++
 tb/tb_bitwise_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitwise_pkg.sv
// rtl/bitwise_pkg.sv - op encodings shared by the bitwise ALU pipeline
package bitwise_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

endpackage

// File: rtl/bitwise_alu_pipe_if.sv
// rtl/bitwise_alu_pipe_if.sv - operand/result handshake bundle of the bitwise ALU pipeline
interface bitwise_alu_pipe_if #(
  parameter int WIDTH = 16
);
  import bitwise_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic [CNT_W-1:0] out_popcnt;

  // Producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_ones, out_parity, out_popcnt
  );

  // ALU side
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_ones, out_parity, out_popcnt
  );

endinterface

// File: rtl/bitwise_flags.sv
// rtl/bitwise_flags.sv - combinational zero/all-ones/parity/popcount of a result word
module bitwise_flags #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] popcnt
);

  assign zero   = (res == '0);
  assign ones   = (res == '1);
  assign parity = ^res;

  // Population count as a simple adder chain over the lanes
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + CNT_W'(res[i]);
    end
  end

endmodule

// File: rtl/bitwise_alu_pipe.sv
// rtl/bitwise_alu_pipe.sv - two-stage bitwise ALU with accumulator chaining and result flags
module bitwise_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bitwise_alu_pipe_if.slave bus
);
  import bitwise_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_fire;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] s1_res;
  logic             f_zero;
  logic             f_ones;
  logic             f_parity;
  logic [CNT_W-1:0] f_popcnt;

  // Ready chain: stage 2 drains when empty or accepted, stage 1 moves when stage 2 does
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign a_sel        = bus.in_acc ? acc : bus.in_a;

  // Opcode mux; PASS_A is also the default so an acc read-back leaves acc unchanged
  always_comb begin
    op_res = a_sel;
    case (bus.in_op)
      OP_AND:  op_res = a_sel & bus.in_b;
      OP_OR:   op_res = a_sel | bus.in_b;
      OP_XOR:  op_res = a_sel ^ bus.in_b;
      OP_NAND: op_res = ~(a_sel & bus.in_b);
      OP_NOR:  op_res = ~(a_sel | bus.in_b);
      OP_XNOR: op_res = ~(a_sel ^ bus.in_b);
      OP_ANDN: op_res = a_sel & ~bus.in_b;
      default: op_res = a_sel;
    endcase
  end

  // Accumulator: clear beats write-back; the op itself already used the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end else if (in_fire && bus.in_acc) begin
      acc <= op_res;
    end
  end

  // Stage 1: execute, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_res <= op_res;
      end
    end
  end

  bitwise_flags #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_flags (
    .res    (s1_res),
    .zero   (f_zero),
    .ones   (f_ones),
    .parity (f_parity),
    .popcnt (f_popcnt)
  );

  // Stage 2: register result and flags together so the outputs stay coherent while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid       <= 1'b0;
      bus.out_res    <= '0;
      bus.out_zero   <= 1'b0;
      bus.out_ones   <= 1'b0;
      bus.out_parity <= 1'b0;
      bus.out_popcnt <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_res    <= s1_res;
        bus.out_zero   <= f_zero;
        bus.out_ones   <= f_ones;
        bus.out_parity <= f_parity;
        bus.out_popcnt <= f_popcnt;
      end
    end
  end

  assign bus.out_valid = s2_valid;

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// tb/tb_bitwise_alu_pipe.sv - directed vector bench for bitwise_alu_pipe
module tb_bitwise_alu_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        acc;
    logic        clr;
    logic [15:0] res;
    logic        zero;
    logic        ones;
    logic        parity;
    logic [4:0]  pop;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitwise_alu_pipe_if #(.WIDTH(16)) bus16 ();
  bitwise_alu_pipe_if #(.WIDTH(8))  bus8 ();
  bitwise_alu_pipe_if #(.WIDTH(33)) bus33 ();

  bitwise_alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  bitwise_alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bitwise_alu_pipe #(.WIDTH(33)) dut33 (.clk(clk), .rst_n(rst_n), .bus(bus33));

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fire_cnt = 0;
  bit   check_lat = 1'b1;
  bit   hold_v = 1'b0;
  logic [15:0] hold_res;
  vec_t cur;
  vec_t expq[$];
  int   cycq[$];
  vec_t tab[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                              input logic acc, input logic clr, input logic [15:0] res,
                              input logic z, input logic o, input logic p, input logic [4:0] pop);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.acc = acc; v.clr = clr;
    v.res = res; v.zero = z; v.ones = o; v.parity = p; v.pop = pop;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard on the 16-bit instance, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      cycq.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("held_valid", bus16.out_valid, 1);
        chk("held_res", bus16.out_res, hold_res);
      end
      if (bus16.in_valid && bus16.in_ready) begin
        expq.push_back(cur);
        cycq.push_back(cyc);
        fire_cnt++;
      end
      if (bus16.out_valid && bus16.out_ready) begin
        hold_v = 1'b0;
        if (expq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          vec_t e;
          int   c;
          e = expq.pop_front();
          c = cycq.pop_front();
          chk("res", bus16.out_res, e.res);
          chk("zero", bus16.out_zero, e.zero);
          chk("ones", bus16.out_ones, e.ones);
          chk("parity", bus16.out_parity, e.parity);
          chk("popcnt", bus16.out_popcnt, e.pop);
          if (check_lat) chk("latency", cyc - c, 2);
        end
      end else if (bus16.out_valid) begin
        hold_v   = 1'b1;
        hold_res = bus16.out_res;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Present one beat starting just after a rising edge; returns after it is accepted
  task automatic send(input vec_t v, output int waited);
    waited = 0;
    cur = v;
    bus16.in_a = v.a; bus16.in_b = v.b; bus16.in_op = v.op;
    bus16.in_acc = v.acc; bus16.acc_clr = v.clr; bus16.in_valid = 1'b1;
    @(negedge clk);
    while (!bus16.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("send_timeout", waited, 0);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.acc_clr  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [7:0]  e8  [9];
  logic [32:0] e33 [9];

  initial begin
    int w;
    int base;
    // case 1
    tab[0]  = mk(16'h0002, 16'h0002, 3'd0, 0, 0, 16'h0002, 0, 0, 1, 5'd1);
    tab[1]  = mk(16'h0002, 16'h0002, 3'd1, 0, 0, 16'h0002, 0, 0, 1, 5'd1);
    tab[2]  = mk(16'h0002, 16'h0002, 3'd2, 0, 0, 16'h0000, 1, 0, 0, 5'd0);
    // case 2
    tab[3]  = mk(16'h0003, 16'h0005, 3'd0, 0, 0, 16'h0001, 0, 0, 1, 5'd1);
    tab[4]  = mk(16'h0003, 16'h0005, 3'd1, 0, 0, 16'h0007, 0, 0, 1, 5'd3);
    tab[5]  = mk(16'h0003, 16'h0005, 3'd2, 0, 0, 16'h0006, 0, 0, 0, 5'd2);
    tab[6]  = mk(16'h0003, 16'h0005, 3'd3, 0, 0, 16'hFFFE, 0, 0, 1, 5'd15);
    tab[7]  = mk(16'h0003, 16'h0005, 3'd4, 0, 0, 16'hFFF8, 0, 0, 1, 5'd13);
    tab[8]  = mk(16'h0003, 16'h0005, 3'd5, 0, 0, 16'hFFF9, 0, 0, 0, 5'd14);
    tab[9]  = mk(16'h0003, 16'h0005, 3'd6, 0, 0, 16'h0002, 0, 0, 1, 5'd1);
    tab[10] = mk(16'h0003, 16'h0005, 3'd7, 0, 0, 16'h0003, 0, 0, 0, 5'd2);
    tab[11] = mk(16'h0000, 16'h0000, 3'd4, 0, 0, 16'hFFFF, 0, 1, 0, 5'd16);
    tab[12] = mk(16'hFFFF, 16'h0F0F, 3'd2, 0, 0, 16'hF0F0, 0, 0, 0, 5'd8);
    // case 4: preload acc, then chain after a clear (in_a is junk, must be ignored)
    tab[13] = mk(16'hFFFF, 16'h1234, 3'd1, 1, 0, 16'h1234, 0, 0, 1, 5'd5);
    tab[14] = mk(16'hFFFF, 16'h00F0, 3'd1, 1, 0, 16'h00F0, 0, 0, 0, 5'd4);
    tab[15] = mk(16'hFFFF, 16'h0F00, 3'd1, 1, 0, 16'h0FF0, 0, 0, 0, 5'd8);
    tab[16] = mk(16'hFFFF, 16'h0FF0, 3'd2, 1, 0, 16'h0000, 1, 0, 0, 5'd0);
    // case 5
    tab[17] = mk(16'hFFFF, 16'h0010, 3'd1, 1, 0, 16'h0010, 0, 0, 1, 5'd1);
    tab[18] = mk(16'hFFFF, 16'hFFFF, 3'd0, 0, 0, 16'hFFFF, 0, 1, 0, 5'd16);
    tab[19] = mk(16'h5555, 16'h1234, 3'd7, 1, 0, 16'h0010, 0, 0, 1, 5'd1);
    tab[20] = mk(16'hFFFF, 16'h0001, 3'd1, 1, 1, 16'h0011, 0, 0, 0, 5'd2);
    tab[21] = mk(16'hAAAA, 16'h0000, 3'd7, 1, 0, 16'h0000, 1, 0, 0, 5'd0);
    // case 6: acc read-back after reset
    tab[22] = mk(16'h5A5A, 16'h0000, 3'd7, 1, 0, 16'h0000, 1, 0, 0, 5'd0);

    e8  = '{8'h01, 8'h07, 8'h06, 8'hFE, 8'hF8, 8'hF9, 8'h02, 8'h03, 8'hFF};
    e33 = '{33'h1, 33'h7, 33'h6, 33'h1_FFFF_FFFE, 33'h1_FFFF_FFF8, 33'h1_FFFF_FFF9,
            33'h2, 33'h3, 33'h1_FFFF_FFFF};

    bus16.in_valid = 0; bus16.in_a = 0; bus16.in_b = 0; bus16.in_op = 0;
    bus16.in_acc = 0; bus16.acc_clr = 0; bus16.out_ready = 1;
    bus8.in_valid = 0; bus8.in_a = 0; bus8.in_b = 0; bus8.in_op = 0;
    bus8.in_acc = 0; bus8.acc_clr = 0; bus8.out_ready = 1;
    bus33.in_valid = 0; bus33.in_a = 0; bus33.in_b = 0; bus33.in_op = 0;
    bus33.in_acc = 0; bus33.acc_clr = 0; bus33.out_ready = 1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_out_res", bus16.out_res, 0);
    chk("rst_flags", {bus16.out_zero, bus16.out_ones, bus16.out_parity}, 0);
    chk("rst_popcnt", bus16.out_popcnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus16.in_ready, 1);

    // cases 1 and 2: back-to-back stream, latency 2, in_ready never drops
    for (int i = 0; i <= 12; i++) begin
      send(tab[i], w);
      chk("stream_in_ready", w, 0);
    end
    drain();

    // case 3: consumer stalls 5 clk; two beats accepted, then in_ready low
    check_lat = 1'b0;
    base = fire_cnt;
    bus16.out_ready = 1'b0;
    fork
      begin
        for (int i = 3; i <= 10; i++) send(tab[i], w);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("stall_in_ready", bus16.in_ready, 0);
        chk("stall_accepted", fire_cnt - base, 2);
        repeat (3) @(posedge clk);
        #1;
        bus16.out_ready = 1'b1;
      end
    join
    drain();
    check_lat = 1'b1;

    // case 4: preload, standalone clear, then chained accumulator ops
    send(tab[13], w);
    bus16.acc_clr = 1'b1;
    @(posedge clk); #1;
    bus16.acc_clr = 1'b0;
    for (int i = 14; i <= 16; i++) send(tab[i], w);
    drain();

    // case 5: non-acc op leaves acc alone; clear wins against same-cycle write-back
    for (int i = 17; i <= 21; i++) send(tab[i], w);
    drain();

    // case 6: reset with two beats in flight
    bus16.out_ready = 1'b0;
    send(mk(16'h0000, 16'h00AA, 3'd1, 1, 0, 16'h00AA, 0, 0, 0, 5'd4), w);
    send(mk(16'h0001, 16'h0001, 3'd0, 0, 0, 16'h0001, 0, 0, 1, 5'd1), w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus16.out_valid, 0);
    chk("midrst_out_res", bus16.out_res, 0);
    chk("midrst_in_ready", bus16.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", bus16.out_valid, 0);
    end
    @(posedge clk); #1;
    send(tab[22], w);
    drain();

    // WIDTH=8 and WIDTH=33 streaming, fixed 2-cycle latency
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      bus8.in_valid  = (i < 9);
      bus33.in_valid = (i < 9);
      if (i < 8) begin
        bus8.in_a  = 8'd3;  bus8.in_b  = 8'd5;  bus8.in_op  = 3'(i);
        bus33.in_a = 33'd3; bus33.in_b = 33'd5; bus33.in_op = 3'(i);
      end else begin
        bus8.in_a  = '0; bus8.in_b  = '0; bus8.in_op  = 3'd4;
        bus33.in_a = '0; bus33.in_b = '0; bus33.in_op = 3'd4;
      end
      @(negedge clk);
      if (i >= 2) begin
        chk("w8_valid", bus8.out_valid, 1);
        chk("w8_res", bus8.out_res, e8[i-2]);
        chk("w33_valid", bus33.out_valid, 1);
        chk("w33_res", bus33.out_res, e33[i-2]);
      end
      if (i == 10) begin
        chk("w8_popcnt_ones", bus8.out_popcnt, 8);
        chk("w8_ones", bus8.out_ones, 1);
        chk("w33_popcnt_ones", bus33.out_popcnt, 33);
        chk("w33_ones", bus33.out_ones, 1);
        chk("w33_parity", bus33.out_parity, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
